fp_serial_tx: RTL and testbench

FP_SERIAL_TX -- requirements
Module: fp_serial_tx

---
 rtl/fp_serial_pkg.sv | 21 ++
 rtl/fp_serial_tx_if.sv | 22 ++
 rtl/fp_serial_tx_bit_timer.sv | 30 +++
 rtl/fp_serial_tx.sv | 102 ++++++++++
 tb/tb_fp_serial_tx.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp_serial_pkg.sv
// Shared types and constants for the floating-point serial transmitter.
// Latency: n/a.
// Backpressure: n/a.
package fp_serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/fp_serial_tx_if.sv
// Upstream handshake, converted FP fields and serial line for fp_serial_tx.
// Latency: n/a.
// Backpressure: in_ready gates acceptance; in_valid may stay high.
interface fp_serial_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic       S;
    logic [2:0] E;
    logic [3:0] F;
    logic       tx;
    logic       busy;

    modport master (
        output in_valid, S, E, F,
        input  in_ready, tx, busy
    );

    modport slave (
        input  in_valid, S, E, F,
        output in_ready, tx, busy
    );
endinterface

// File: rtl/fp_serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high, ticks bit_done on the last count.
// Latency: bit_done is combinational from the registered count.
// Backpressure: none; clear restarts the count at frame start.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic bit_done
);

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? 16'd0 : cnt + 16'd1;
        end
    end

    assign bit_done = run && !clear && (cnt == LAST);

endmodule

// File: rtl/fp_serial_tx.sv
// Serialises {S,E,F} as start, 8 data bits MSB first, even parity, stop; each bit CLKS_PER_BIT cycles.
// Latency: start bit on tx one cycle after the accepting edge.
// Backpressure: in_ready only in IDLE, so a new value is taken one cycle after each stop bit.
module fp_serial_tx
    import fp_serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input logic        clk,
    input logic        rst,
    fp_serial_tx_if.slave bus
);

    state_t         state, state_nxt;
    logic           tx_q, tx_nxt;
    logic [7:0]     d8, d8_nxt;
    logic [2:0]     bit_idx, idx_nxt;
    logic           xfer;
    logic           bit_done;

    assign bus.in_ready = (state == ST_IDLE);
    assign bus.busy     = (state != ST_IDLE);
    assign bus.tx       = tx_q;
    assign xfer         = bus.in_valid && bus.in_ready;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (xfer),
        .run      (bus.busy),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            tx_q    <= 1'b1;
            d8      <= 8'h00;
            bit_idx <= 3'(DATA_BITS - 1);
        end else begin
            state   <= state_nxt;
            tx_q    <= tx_nxt;
            d8      <= d8_nxt;
            bit_idx <= idx_nxt;
        end
    end

    // tx is computed alongside the state so each bit lands on the line with its state change.
    always_comb begin
        state_nxt = state;
        tx_nxt    = tx_q;
        d8_nxt    = d8;
        idx_nxt   = bit_idx;
        case (state)
            ST_IDLE: begin
                tx_nxt = 1'b1;
                if (xfer) begin
                    state_nxt = ST_START;
                    tx_nxt    = 1'b0;
                    d8_nxt    = {bus.S, bus.E, bus.F};
                    idx_nxt   = 3'(DATA_BITS - 1);
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_nxt = ST_DATA;
                    tx_nxt    = d8[bit_idx];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'd0) begin
                        state_nxt = ST_PARITY;
                        tx_nxt    = even_parity(d8);
                    end else begin
                        idx_nxt = bit_idx - 3'd1;
                        tx_nxt  = d8[bit_idx - 3'd1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_nxt = ST_STOP;
                    tx_nxt    = 1'b1;
                end
            end
            ST_STOP: begin
                tx_nxt = 1'b1;
                if (bit_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_fp_serial_tx.sv
// Bench for fp_serial_tx at CLKS_PER_BIT = 4 and 1, with a per-cycle line model and literal frame checks.
module tb_fp_serial_tx;
    import fp_serial_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_serial_tx_if if4();
    fp_serial_tx_if if1();

    fp_serial_tx #(.CLKS_PER_BIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    fp_serial_tx #(.CLKS_PER_BIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    int n_vec = 0;
    int n_err = 0;

    // Expected tx value for each upcoming cycle; empty means the line is idle and ready.
    bit q4[$];
    bit q1[$];
    bit r4, r1;

    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        return {1'b0, d, ^d, 1'b1};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge rst) begin
        q4.delete();
        q1.delete();
    end

    always @(posedge clk) begin
        if (rst) begin
            q4.delete();
            q1.delete();
        end else begin
            r4 = (q4.size() == 0);
            r1 = (q1.size() == 0);
            if (!r4) void'(q4.pop_front());
            if (!r1) void'(q1.pop_front());
            if (r4 && if4.in_valid) begin
                logic [10:0] fb;
                fb = frame_bits({if4.S, if4.E, if4.F});
                for (int b = 10; b >= 0; b--)
                    for (int k = 0; k < 4; k++) q4.push_back(fb[b]);
            end
            if (r1 && if1.in_valid) begin
                logic [10:0] fb;
                fb = frame_bits({if1.S, if1.E, if1.F});
                for (int b = 10; b >= 0; b--) q1.push_back(fb[b]);
            end
        end
    end

    always @(negedge clk) begin
        check("tx4",   if4.tx,       (q4.size() != 0) ? q4[0] : 1'b1);
        check("busy4", if4.busy,     q4.size() != 0);
        check("rdy4",  if4.in_ready, q4.size() == 0);
        check("tx1",   if1.tx,       (q1.size() != 0) ? q1[0] : 1'b1);
        check("busy1", if1.busy,     q1.size() != 0);
        check("rdy1",  if1.in_ready, q1.size() == 0);
    end

    task automatic wait_ready(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((which == 1) ? if1.in_ready : if4.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout%0d: in_ready never rose within 200 cycles", which);
        end
    endtask

    task automatic send(input int which, input logic [7:0] d);
        bit ok;
        wait_ready(which, ok);
        #1;
        if (which == 1) begin
            if1.in_valid = 1'b1; {if1.S, if1.E, if1.F} = d;
        end else begin
            if4.in_valid = 1'b1; {if4.S, if4.E, if4.F} = d;
        end
        @(posedge clk);
        #1;
        if (which == 1) begin
            if1.in_valid = 1'b0; {if1.S, if1.E, if1.F} = ~d;
        end else begin
            if4.in_valid = 1'b0; {if4.S, if4.E, if4.F} = ~d;
        end
    endtask

    task automatic capture(input int which, input int n, output logic [63:0] s);
        s = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s = {s[62:0], (which == 1) ? if1.tx : if4.tx};
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [63:0] s;
        logic [10:0] exp_a, exp_z, exp_f;
        logic [7:0]  vals [3];
        int          t_rdy [4];
        int          k, cyc, cnt;
        bit          ok;

        exp_a = 11'b0_11011100_1_1;
        exp_z = 11'b0_00000000_0_1;
        exp_f = 11'b0_11111111_0_1;
        vals[0] = 8'hA5; vals[1] = 8'h3C; vals[2] = 8'h81;

        if4.in_valid = 1'b0; {if4.S, if4.E, if4.F} = 8'h00;
        if1.in_valid = 1'b0; {if1.S, if1.E, if1.F} = 8'h00;

        check("pin_frame_dc", frame_bits(8'hDC), exp_a);
        check("pin_frame_00", frame_bits(8'h00), exp_z);
        check("pin_frame_ff", frame_bits(8'hFF), exp_f);

        repeat (2) @(negedge clk);
        #1;
        check("rst_tx4", if4.tx, 1'b1);
        check("rst_rdy4", if4.in_ready, 1'b1);
        check("rst_busy4", if4.busy, 1'b0);

        // First transfer on the first edge after reset release.
        rst = 1'b0;
        if4.in_valid = 1'b1;
        {if4.S, if4.E, if4.F} = {1'b1, 3'b101, 4'b1100};
        @(posedge clk);
        #1;
        if4.in_valid = 1'b0;
        {if4.S, if4.E, if4.F} = 8'h23;
        capture(4, 44, s);
        for (int b = 0; b < 11; b++)
            check($sformatf("dc_bit%0d", b), s[43 - (b * 4 + 2)], exp_a[10 - b]);
        check("dc_first_cycle", s[43], 1'b0);
        check("dc_last_cycle", s[0], 1'b1);
        @(negedge clk);
        check("dc_idle_rdy", if4.in_ready, 1'b1);

        // All-zero value: busy for exactly 44 cycles.
        send(4, 8'h00);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (if4.busy) cnt++;
        end
        check("zero_busy_cycles", cnt, 44);

        // Three values with in_valid held high; garbage on the fields while busy.
        wait_ready(4, ok);
        k = 0;
        cyc = 0;
        t_rdy[3] = -1;
        #1;
        if4.in_valid = 1'b1;
        {if4.S, if4.E, if4.F} = vals[0];
        t_rdy[0] = 0;
        k = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cyc++;
            #1;
            if (if4.in_ready) begin
                if (k < 3) begin
                    t_rdy[k] = cyc;
                    {if4.S, if4.E, if4.F} = vals[k];
                    k++;
                end else begin
                    t_rdy[3] = cyc;
                    if4.in_valid = 1'b0;
                    break;
                end
            end else begin
                {if4.S, if4.E, if4.F} = 8'($urandom);
            end
        end
        check("b2b_frames", k, 3);
        check("b2b_gap01", t_rdy[1] - t_rdy[0], 45);
        check("b2b_gap12", t_rdy[2] - t_rdy[1], 45);
        check("b2b_gap23", t_rdy[3] - t_rdy[2], 45);

        // Reset in the middle of the data bits.
        send(4, 8'h00);
        repeat (12) @(negedge clk);
        check("mid_data_tx", if4.tx, 1'b0);
        check("mid_data_busy", if4.busy, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_tx4", if4.tx, 1'b1);
        check("arst_rdy4", if4.in_ready, 1'b1);
        check("arst_busy4", if4.busy, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("no_resume_busy", if4.busy, 1'b0);
        check("no_resume_tx", if4.tx, 1'b1);

        // One clock per bit, all-ones value.
        send(1, 8'hFF);
        capture(1, 11, s);
        for (int b = 0; b < 11; b++)
            check($sformatf("ff_bit%0d", b), s[10 - b], exp_f[10 - b]);
        @(negedge clk);
        check("ff_rdy_cycle12", if1.in_ready, 1'b1);
        send(1, 8'h5A);
        repeat (15) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
